// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if: decode/writeback bus into the register file and scoreboard
interface reg_file_scoreboard_if #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2
);
    localparam int AW = $clog2(DEPTH);
    logic                      w_en;
    logic [AW-1:0]             write_rg;
    logic [WIDTH-1:0]          write_data;
    logic                      issue_en;
    logic [AW-1:0]             issue_rg;
    logic [NUM_READ*AW-1:0]    read_rg;
    logic [NUM_READ*WIDTH-1:0] read_data;
    logic [NUM_READ-1:0]       rd_busy;
    logic [AW:0]               busy_count;
    modport master (
        output w_en, write_rg, write_data, issue_en, issue_rg, read_rg,
        input  read_data, rd_busy, busy_count
    );
    modport slave (
        input  w_en, write_rg, write_data, issue_en, issue_rg, read_rg,
        output read_data, rd_busy, busy_count
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: parametrised register file with per-register busy scoreboard
module reg_file_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                clk,
    input logic                rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]                regs_q [DEPTH];
    logic [DEPTH-1:0]                busy_q, busy_d;
    logic [AW:0]                     count_q, count_d;
    logic                            w_ok, i_ok;
    logic [NUM_READ-1:0][WIDTH-1:0]  rdata;
    logic [NUM_READ-1:0]             rbusy;

    function automatic logic legal(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign w_ok = bus.w_en && legal(bus.write_rg);
    assign i_ok = bus.issue_en && legal(bus.issue_rg);

    // writeback clears, issue sets; issue is applied last so the newest writer wins
    always_comb begin
        busy_d = busy_q;
        if (w_ok) busy_d[bus.write_rg] = 1'b0;
        if (i_ok) busy_d[bus.issue_rg] = 1'b1;
        count_d = (AW+1)'($countones(busy_d));
    end

    // scoreboard and busy counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // register storage; illegal addresses never reach here through w_ok
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (w_ok) begin
            regs_q[bus.write_rg] <= bus.write_data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok, hit;
        assign ra       = bus.read_rg[k*AW +: AW];
        assign ok       = legal(ra);
        assign hit      = (BYPASS != 0) && bus.w_en && (bus.write_rg == ra);
        assign rdata[k] = !ok ? '0 : hit ? bus.write_data : regs_q[ra];
        assign rbusy[k] = ok && busy_q[ra] && !hit;
    end

    assign bus.read_data  = rdata;
    assign bus.rd_busy    = rbusy;
    assign bus.busy_count = count_q;
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the core's 32x32 register file.
- Configurable width, depth and number of read ports, with optional hardwired-zero register 0 and optional write-to-read bypass.
- Integrated per-register busy scoreboard: decode marks a destination pending at issue, writeback clears it. The pipeline's hazard logic stalls on rd_busy instead of comparing addresses itself.
- Sits between decode (read/issue) and writeback (write) in the brisc pipeline.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; 2..64; need not be a power of two.
- NUM_READ, 2, number of read ports; 1..4.
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- AW, derived, $clog2(DEPTH), address width. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- w_en  input  1  write enable.
- write_rg  input  AW  write address.
- write_data  input  WIDTH  write data.
- issue_en  input  1  mark issue_rg pending.
- issue_rg  input  AW  destination register being issued.
- read_rg  input  NUM_READ*AW  packed read addresses; port k is bits [k*AW +: AW].
- read_data  output  NUM_READ*WIDTH  packed read data; port k is bits [k*WIDTH +: WIDTH].
- rd_busy  output  NUM_READ  bit k = port k's register has an outstanding writer.
- busy_count  output  AW+1  number of registers currently busy.

Behaviour:
- Reset: when rst=1 at a rising edge, all registers go to 0, all busy bits go to 0, and busy_count goes to 0. Reset overrides any write or issue in that cycle. Reset mid-stream drops all pending state; in-flight writebacks after reset are ordinary writes.
- Legal address: an address a is legal when a < DEPTH and not (ZERO_REG=1 and a=0).
- Reads are combinational with zero latency:
  - Port k returns 0 when its address is illegal.
  - Otherwise, with BYPASS=1, w_en=1 and write_rg equal to the port's address, it returns write_data in the same cycle.
  - Otherwise it returns the stored value.
- Write: when w_en=1 and write_rg is legal, the register takes write_data at the edge, and the busy bit for write_rg is cleared at the same edge. Illegal write addresses are ignored with no state change.
- Issue: when issue_en=1 and issue_rg is legal, the busy bit for issue_rg is set at the edge. Issuing to an already-busy register keeps it busy; there is no counting of multiple writers.
- Same register issued and written in one cycle: issue wins and the busy bit ends at 1, because the new instruction is the newest writer. The data write still happens.
- rd_busy for port k:
  - 1 when the port's address is legal and its busy bit is 1, except when BYPASS=1 and a write to that address is occurring this cycle (the data is forwarded, so there is no stall).
  - With BYPASS=0 a same-cycle write does not mask rd_busy.
  - An issue in the current cycle never affects the current cycle's rd_busy.
- busy_count:
  - Registered; always equals the popcount of the busy bits after each edge.
  - Per cycle it updates by +1 (set of a not-busy register), -1 (clear of a busy register without a same-address issue), or 0.
  - A simultaneous set of register A and clear of register B gives net 0.
  - Maximum value is DEPTH-ZERO_REG; it never wraps.
- Register 0 when ZERO_REG=0 is an ordinary register.

Test Plan:
- Reset with defaults: assert rst for 1 cycle after writing x5=0xDEADBEEF -> read of x5 returns 0, rd_busy=0, busy_count=0.
- Zero register: w_en=1, write_rg=0, write_data=0x1234 and issue_en=1, issue_rg=0, then read port 0 at address 0 -> read_data=0, rd_busy[0]=0, busy_count=0.
- Bypass: with BYPASS=1, issue x3 in cycle 0; in cycle 2 write x3=0xCAFE0001 while port 1 reads x3 -> port 1 returns 0xCAFE0001 that cycle, rd_busy[1]=0, and busy_count falls 1->0 at the edge. With BYPASS=0 the same stimulus returns the old value and rd_busy[1]=1.
- Issue/write collision: x7 busy; issue x7 and write x7=0x55 in one cycle -> next cycle x7 reads 0x55, rd_busy=1, busy_count unchanged at 1.
- Mixed count: issue x1, x2, x4 on consecutive cycles -> busy_count 1, 2, 3. Then issue x9 while writing x2 in one cycle -> busy_count stays 3.
- Non-power-of-two: with DEPTH=24 and NUM_READ=3, write address 30 and issue address 30 -> no state change, busy_count=0, and all three ports reading address 30 return 0 with rd_busy=0.
